// File: rtl/alu_pkg.sv
// Shared types and constants for the multicycle ALU: control codes, FSM states
// and the instruction-field constants used by the decoder.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_AND    = 4'b0010,
    ALU_OR     = 4'b0011,
    ALU_XOR    = 4'b0100,
    ALU_SLT    = 4'b0101,
    ALU_SLL    = 4'b0110,
    ALU_SRL    = 4'b0111,
    ALU_SRA    = 4'b1000,
    ALU_SLTU   = 4'b1001,
    ALU_MUL    = 4'b1010,
    ALU_MULH   = 4'b1011,
    ALU_MULHSU = 4'b1100,
    ALU_MULHU  = 4'b1101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    FIX,
    DONE
  } state_e;

  localparam int         OP_RTYPE_BIT  = 5;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational control decoder: ALUOp/funct3/funct7/opcode to a control code,
// plus flags for the iterative multiplier path and unsupported encodings.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic [6:0] op_i,
  output alu_ctrl_e  ctrl_o,
  output logic       is_mul_o,
  output logic       illegal_o
);

  logic rtype;
  logic unused_op;

  assign rtype     = op_i[OP_RTYPE_BIT];
  assign unused_op = ^{op_i[6], op_i[4:0]};

  // The M-extension row only applies to register-register ops; divides are unsupported.
  always_comb begin
    ctrl_o    = ALU_ADD;
    is_mul_o  = 1'b0;
    illegal_o = 1'b0;
    unique case (alu_op_i)
      2'b00: ctrl_o = ALU_ADD;
      2'b01: ctrl_o = ALU_SUB;
      2'b10: begin
        if (rtype && (funct7_i == FUNCT7_MULDIV)) begin
          if (funct3_i[2]) begin
            illegal_o = 1'b1;
          end else begin
            is_mul_o = 1'b1;
            case (funct3_i[1:0])
              2'b00:   ctrl_o = ALU_MUL;
              2'b01:   ctrl_o = ALU_MULH;
              2'b10:   ctrl_o = ALU_MULHSU;
              default: ctrl_o = ALU_MULHU;
            endcase
          end
        end else begin
          case (funct3_i)
            3'b000:  ctrl_o = (rtype && funct7_i[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  ctrl_o = ALU_SLL;
            3'b010:  ctrl_o = ALU_SLT;
            3'b011:  ctrl_o = ALU_SLTU;
            3'b100:  ctrl_o = ALU_XOR;
            3'b101:  ctrl_o = funct7_i[5] ? ALU_SRA : ALU_SRL;
            3'b110:  ctrl_o = ALU_OR;
            default: ctrl_o = ALU_AND;
          endcase
        end
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_multicycle_unit.sv
// Multicycle ALU: single-cycle RV32I ops and an iterative shift-add RV32M
// multiplier, with valid/ready handshakes on the request and result sides.
module alu_multicycle_unit
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [6:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int                NSTEPS   = XLEN / MUL_STEP;
  localparam int                CNT_W    = $clog2(NSTEPS);
  localparam int                SH_W     = $clog2(XLEN);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NSTEPS - 1);

  alu_ctrl_e dec_ctrl;
  logic      dec_is_mul;
  logic      dec_illegal;

  alu_ctrl_dec u_dec (
    .alu_op_i (ALUOp),
    .funct3_i (funct3),
    .funct7_i (funct7),
    .op_i     (op),
    .ctrl_o   (dec_ctrl),
    .is_mul_o (dec_is_mul),
    .illegal_o(dec_illegal)
  );

  state_e              state_q, state_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                illegal_q, illegal_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                neg_q, neg_d;
  logic                mul_hi_q, mul_hi_d;

  logic                accept;
  logic [SH_W-1:0]     shamt;
  logic [XLEN-1:0]     alu_res;
  logic                a_neg, b_neg;
  logic [2*XLEN-1:0]   partial;
  logic [2*XLEN-1:0]   product;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign illegal   = illegal_q;
  assign shamt     = src_b[SH_W-1:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = dec_is_mul ? MUL : DONE;
      MUL:  if (count_q == LAST_CNT) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: begin
        if (out_ready) state_d = accept ? (dec_is_mul ? MUL : DONE) : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (dec_ctrl)
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      ALU_SLL:  alu_res = src_a << shamt;
      ALU_SRL:  alu_res = src_a >> shamt;
      ALU_SRA:  alu_res = XLEN'($signed(src_a) >>> shamt);
      default:  alu_res = '0;
    endcase
  end

  // The multiplier works on magnitudes; the product sign is restored in FIX.
  assign a_neg   = ((dec_ctrl == ALU_MULH) || (dec_ctrl == ALU_MULHSU)) && src_a[XLEN-1];
  assign b_neg   = (dec_ctrl == ALU_MULH) && src_b[XLEN-1];
  assign product = neg_q ? (~acc_q + 1'b1) : acc_q;

  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end
  end

  always_comb begin
    result_d  = result_q;
    illegal_d = illegal_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    neg_d     = neg_q;
    mul_hi_d  = mul_hi_q;
    if (accept) begin
      if (dec_is_mul) begin
        acc_d     = '0;
        mcand_d   = {{XLEN{1'b0}}, (a_neg ? (~src_a + 1'b1) : src_a)};
        mplier_d  = b_neg ? (~src_b + 1'b1) : src_b;
        count_d   = '0;
        neg_d     = a_neg ^ b_neg;
        mul_hi_d  = (dec_ctrl != ALU_MUL);
        illegal_d = 1'b0;
      end else begin
        result_d  = dec_illegal ? '0 : alu_res;
        illegal_d = dec_illegal;
      end
    end else if (state_q == MUL) begin
      acc_d    = acc_q + partial;
      mcand_d  = mcand_q << MUL_STEP;
      mplier_d = mplier_q >> MUL_STEP;
      count_d  = count_q + 1'b1;
    end else if (state_q == FIX) begin
      result_d = mul_hi_q ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q  <= '0;
      illegal_q <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      mul_hi_q  <= 1'b0;
    end else begin
      result_q  <= result_d;
      illegal_q <= illegal_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      mul_hi_q  <= mul_hi_d;
    end
  end

endmodule

// File: tb/tb_alu_multicycle_unit.sv
// Scoreboard bench for alu_multicycle_unit: a driver pushes expected responses
// from a plain-arithmetic reference model, a monitor pops them on each result.
module tb_alu_multicycle_unit;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ALUOp;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [6:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
  } dir_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          seen = 0;
  bit          holding = 0;
  logic [31:0] heldRes;
  logic        heldZero;
  logic        heldIll;

  alu_multicycle_unit dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ALUOp    (ALUOp),
    .funct3   (funct3),
    .funct7   (funct7),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .illegal  (illegal)
  );

  // Free-running clock and a cycle counter used for latency bookkeeping.
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop so that a wedged handshake can never hang the run.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model written straight from the instruction semantics with 64-bit arithmetic.
  function automatic exp_t model(input logic [1:0] aluop, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [6:0] opc, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    int          sa;
    int          sbv;
    int          sh;
    longint      ps;
    logic [63:0] pu;
    e.res = 32'h0;
    e.ill = 1'b0;
    e.lat = 1;
    e.acc = 0;
    sa    = a;
    sbv   = b;
    sh    = int'(b[4:0]);
    case (aluop)
      2'b00: e.res = a + b;
      2'b01: e.res = a - b;
      2'b11: e.ill = 1'b1;
      default: begin
        if (opc[5] && f7 == 7'b0000001) begin
          if (f3[2]) begin
            e.ill = 1'b1;
          end else begin
            e.lat = 34;
            case (f3[1:0])
              2'b00: begin pu = {32'h0, a} * {32'h0, b}; e.res = pu[31:0]; end
              2'b01: begin ps = longint'(sa) * longint'(sbv); e.res = ps[63:32]; end
              2'b10: begin ps = longint'(sa) * longint'({32'h0, b}); e.res = ps[63:32]; end
              default: begin pu = {32'h0, a} * {32'h0, b}; e.res = pu[63:32]; end
            endcase
          end
        end else begin
          case (f3)
            3'b000: e.res = (opc[5] && f7[5]) ? a - b : a + b;
            3'b001: e.res = a << sh;
            3'b010: e.res = (sa < sbv) ? 32'd1 : 32'd0;
            3'b011: e.res = (a < b) ? 32'd1 : 32'd0;
            3'b100: e.res = a ^ b;
            3'b101: e.res = f7[5] ? 32'(sa >>> sh) : (a >> sh);
            3'b110: e.res = a | b;
            default: e.res = a & b;
          endcase
        end
      end
    endcase
    return e;
  endfunction

  // Offers one request until accepted; while waiting it may drop in_valid with junk on the bus.
  task automatic applyStimulus(input logic [1:0] aluop, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [6:0] opc, input logic [31:0] a, input logic [31:0] b,
                               input bit haveExp, input logic [31:0] expRes, input bit expIll,
                               input bit randReady, output int waits);
    exp_t e;
    bit   done;
    e = model(aluop, f3, f7, opc, a, b);
    if (haveExp) begin
      e.res = expRes;
      e.ill = expIll;
    end
    waits = 0;
    done  = 0;
    while (!done) begin
      if (waits > 0 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        ALUOp    = 2'($urandom);
        funct3   = 3'($urandom);
        funct7   = 7'($urandom);
        op       = 7'($urandom);
        src_a    = $urandom;
        src_b    = $urandom;
      end else begin
        in_valid = 1'b1;
        ALUOp    = aluop;
        funct3   = f3;
        funct7   = f7;
        op       = opc;
        src_a    = a;
        src_b    = b;
      end
      if (randReady) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        e.acc = cyc;
        @(posedge clk);
        sb.push_back(e);
        #1;
        in_valid = 1'b0;
        done     = 1;
      end else begin
        @(posedge clk);
        #1;
        waits++;
        if (waits > 200) begin
          checkOutput("accept_timeout", 64'd0, 64'd1);
          in_valid = 1'b0;
          done     = 1;
        end
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: latency on first sight of a result, stability while stalled, contents on handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (sb.size() > 0 && !seen) begin
        if (out_valid) begin
          checkOutput("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
          seen = 1;
        end else if (cyc - sb[0].acc > sb[0].lat + 3) begin
          checkOutput("result_timeout", 64'd0, 64'd1);
          void'(sb.pop_front());
        end
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_valid", 64'(out_valid), 64'd0);
        end else begin
          if (holding) begin
            checkOutput("hold_result", 64'(result), 64'(heldRes));
            checkOutput("hold_zero", 64'(zero), 64'(heldZero));
            checkOutput("hold_illegal", 64'(illegal), 64'(heldIll));
          end
          if (out_ready) begin
            checkOutput("result", 64'(result), 64'(sb[0].res));
            checkOutput("zero", 64'(zero), 64'(sb[0].res == 32'h0));
            checkOutput("illegal", 64'(illegal), 64'(sb[0].ill));
            void'(sb.pop_front());
            seen    = 0;
            holding = 0;
          end else begin
            holding  = 1;
            heldRes  = result;
            heldZero = zero;
            heldIll  = illegal;
          end
        end
      end
    end
  end

  initial begin
    dir_t dirTab[$];
    int   w;
    logic [1:0] rAluop;
    logic [6:0] rF7;
    int   r;

    rst       = 1'b0;
    in_valid  = 1'b0;
    ALUOp     = 2'b00;
    funct3    = 3'b000;
    funct7    = 7'b0;
    op        = 7'b0;
    src_a     = 32'h0;
    src_b     = 32'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    @(negedge clk);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_result", 64'(result), 64'd0);
    checkOutput("reset_zero", 64'(zero), 64'd1);
    checkOutput("reset_illegal", 64'(illegal), 64'd0);
    @(posedge clk);
    #1;

    dirTab.push_back('{2'b10, 3'b000, 7'b0100000, OPC_R, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0});
    dirTab.push_back('{2'b10, 3'b101, 7'b0100000, OPC_R, 32'h8000_0000, 32'h1F, 32'hFFFF_FFFF, 1'b0});
    dirTab.push_back('{2'b10, 3'b101, 7'b0000000, OPC_R, 32'h8000_0000, 32'h1F, 32'h0000_0001, 1'b0});
    dirTab.push_back('{2'b10, 3'b011, 7'b0000000, OPC_R, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0});
    dirTab.push_back('{2'b10, 3'b010, 7'b0000000, OPC_R, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0});
    dirTab.push_back('{2'b10, 3'b001, 7'b0000001, OPC_R, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 1'b0});
    dirTab.push_back('{2'b10, 3'b011, 7'b0000001, OPC_R, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 1'b0});
    dirTab.push_back('{2'b10, 3'b000, 7'b0000001, OPC_R, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 1'b0});
    dirTab.push_back('{2'b10, 3'b010, 7'b0000001, OPC_R, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 1'b0});
    dirTab.push_back('{2'b10, 3'b100, 7'b0000001, OPC_R, 32'd5, 32'd7, 32'h0, 1'b1});
    dirTab.push_back('{2'b11, 3'b000, 7'b0000000, OPC_R, 32'd5, 32'd7, 32'h0, 1'b1});
    dirTab.push_back('{2'b00, 3'b111, 7'b0100000, OPC_R, 32'd5, 32'd7, 32'd12, 1'b0});
    dirTab.push_back('{2'b01, 3'b000, 7'b0000000, OPC_R, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0});
    dirTab.push_back('{2'b10, 3'b000, 7'b0100000, OPC_I, 32'd5, 32'd7, 32'd12, 1'b0});
    dirTab.push_back('{2'b10, 3'b100, 7'b0000001, OPC_I, 32'd5, 32'd7, 32'd2, 1'b0});
    dirTab.push_back('{2'b10, 3'b001, 7'b0000000, OPC_R, 32'd1, 32'h21, 32'd2, 1'b0});

    $display("[TB] directed vectors");
    foreach (dirTab[i]) begin
      applyStimulus(dirTab[i].aluop, dirTab[i].f3, dirTab[i].f7, dirTab[i].opc,
                    dirTab[i].a, dirTab[i].b, 1'b1, dirTab[i].res, dirTab[i].ill, 1'b0, w);
    end
    drain();

    $display("[TB] back-to-back with stalled consumer");
    out_ready = 1'b0;
    applyStimulus(2'b00, 3'b000, 7'b0, OPC_R, 32'd3, 32'd4, 1'b1, 32'd7, 1'b0, 1'b0, w);
    repeat (3) begin
      @(negedge clk);
      checkOutput("b2b_in_ready_low", 64'(in_ready), 64'd0);
      checkOutput("b2b_out_valid_held", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(2'b01, 3'b000, 7'b0, OPC_R, 32'd20, 32'd3, 1'b1, 32'd17, 1'b0, 1'b0, w);
    checkOutput("b2b_accept_wait", 64'(w), 64'd0);
    drain();

    $display("[TB] reset during multiply");
    applyStimulus(2'b10, 3'b001, 7'b0000001, OPC_R, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'h0, 1'b0, 1'b0, w);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b0;
    sb.delete();
    seen    = 0;
    holding = 0;
    #1;
    checkOutput("midmul_reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midmul_reset_result", 64'(result), 64'd0);
    checkOutput("midmul_reset_zero", 64'(zero), 64'd1);
    checkOutput("midmul_reset_illegal", 64'(illegal), 64'd0);
    @(negedge clk);
    checkOutput("midmul_reset_in_ready", 64'(in_ready), 64'd1);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(2'b10, 3'b011, 7'b0000001, OPC_R, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, w);
    drain();

    $display("[TB] randomized traffic");
    for (int n = 0; n < 250; n++) begin
      r = int'($urandom_range(0, 19));
      if (r < 2)       rAluop = 2'b00;
      else if (r < 4)  rAluop = 2'b01;
      else if (r == 4) rAluop = 2'b11;
      else             rAluop = 2'b10;
      case ($urandom_range(0, 3))
        0:       rF7 = 7'b0000000;
        1:       rF7 = 7'b0100000;
        2:       rF7 = 7'b0000001;
        default: rF7 = 7'($urandom);
      endcase
      applyStimulus(rAluop, 3'($urandom), rF7, ($urandom_range(0, 4) == 0) ? OPC_I : OPC_R,
                    pickOperand(), pickOperand(), 1'b0, 32'h0, 1'b0, 1'b1, w);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
